data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the single-cycle processor's data port. It serves `lw`/`sw` traffic from a word-addressed RAM with a combinational read path, which the single-cycle datapath requires. It also decodes a small memory-mapped I/O window: a transmit FIFO with a valid/ready drain port, a status register, and a free-running cycle counter. It sits between the processor's `address_to_mem`/`data_to_mem`/`write_enable` outputs and its `data_from_mem` input.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two, 4..65536.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `MMIO_BASE`, 32'h1000_0000: base byte address of the MMIO window; 16-byte aligned.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0); clears all MMIO state immediately.
- `write_enable`  in  1  store strobe from processor, sampled at rising edge.
- `address_to_mem`  in  32  byte address.
- `data_to_mem`  in  32  store data.
- `data_from_mem`  out  32  load data, combinational from address.
- `tx_valid`  out  1  FIFO head valid.
- `tx_data`  out  32  FIFO head word.
- `tx_ready`  in  1  consumer accepts head this cycle.

## Operation
- Address bits [1:0] are ignored everywhere; all accesses are whole words.
- RAM region: `address_to_mem` < DEPTH*4.
  - Read returns word `address_to_mem[log2(DEPTH)+1:2]`.
  - Store writes that word at the edge.
  - Reset does not clear RAM.
- MMIO window: `MMIO_BASE` + offset.
  - +0x0 TXDATA. A store pushes `data_to_mem` into the FIFO if accepted; reads return 0.
  - +0x4 STATUS. Read bits are [0] empty, [1] full, [2] overflow (sticky), [8:4] count (0..FIFO_DEPTH), all others 0. A store with `data_to_mem[2]`=1 clears overflow; other bits are ignored.
  - +0x8 CYCLES. 32-bit counter that increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A store loads `data_to_mem`; that value replaces the increment for that edge.
  - +0xC and all unmapped addresses: reads return 0, stores are ignored.
- FIFO acceptance:
  - A push is accepted when not full, or when full and a pop occurs at the same edge.
  - A rejected push is dropped and sets overflow.
  - Pop occurs when `tx_valid` && `tx_ready`.
  - Push and pop at the same edge leave count unchanged; the head advances and the new word goes to the tail.
- FIFO outputs:
  - `tx_valid` = !empty.
  - `tx_data` = head word when valid, 0 when empty.
  - There is no fall-through: a push into an empty FIFO shows `tx_valid`=1 only after that edge.
- Overflow: if an overflow-clear store and a rejected push occur at the same edge, overflow ends at 1 (set wins).
- Read and pointer widths:
  - STATUS/CYCLES reads reflect register state before the current edge.
  - FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally, and use a separate count register.

## Timing
- Reset asserted (low):
  - FIFO empty, count 0, pointers 0, overflow 0, CYCLES 0.
  - `tx_valid`=0, `tx_data`=0.
  - `data_from_mem` still decodes combinationally; RAM reads remain valid.
- Reset mid-operation discards FIFO contents immediately. On the first edge after reset deasserts, CYCLES becomes 1.
- Latencies:
  - Load: 0 cycles (combinational).
  - Store: visible to reads after the capturing edge.
  - `tx_valid` after push: 1 edge.
- Consumer contract: the consumer may hold `tx_ready` high continuously, giving one pop per cycle. `tx_data` must be stable while `tx_valid`=1 and `tx_ready`=0.
- CYCLES store at edge k: a read after k returns the stored value V; a read after edge k+1 returns V+1.

## Test plan
- RAM: store 0xDEAD_BEEF to 0x10, then load 0x10 → 0xDEAD_BEEF. Load 0x13 → 0xDEAD_BEEF. Load DEPTH*4 → 0.
- Reset: reset low for 3 cycles with 2 words queued → `tx_valid`=0, STATUS=0x1, CYCLES=0. After release plus one edge, CYCLES=1.
- FIFO fill with `tx_ready`=0:
  - 4 pushes of 1..4 → STATUS=0x42 (count 4, full).
  - Fifth push of 5 → STATUS=0x46 (overflow set), word 5 dropped.
  - Store 0x4 to STATUS → overflow clears.
- Drain: raise `tx_ready` → `tx_data` 1,2,3,4 on consecutive cycles, then `tx_valid`=0 and `tx_data`=0.
- Full with simultaneous push+pop: push 9 while full with `tx_ready`=1 → accepted, count stays 4, overflow stays 0. 9 appears as the fourth subsequent word.
- Counter: store 0xFFFF_FFFE to CYCLES → subsequent reads give 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Store to unmapped offset 0xC → no state change, reads 0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Processor data-port bus plus the TX FIFO drain port of data_mem_responder.
// Drain handshake: a word transfers on each rising edge where tx_valid && tx_ready; tx_data holds while tx_valid && !tx_ready.
interface data_mem_responder_if;
  logic        write_enable;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport slave (
    input  write_enable, address_to_mem, data_to_mem, tx_ready,
    output data_from_mem, tx_valid, tx_data
  );

  modport master (
    output write_enable, address_to_mem, data_to_mem, tx_ready,
    input  data_from_mem, tx_valid, tx_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM with combinational reads, plus an MMIO window
// holding a TX FIFO, a status register and a free-running cycle counter.
module data_mem_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_ram  [DEPTH];
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [31:0]   r_cycles;

  logic          w_in_ram;
  logic          w_in_mmio;
  logic [1:0]    w_off;
  logic [AW-1:0] w_word;
  logic          w_mmio_we;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_push_rej;
  logic          w_ovf_clr;
  logic          w_cyc_we;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Byte lane bits are don't-care: every access is a whole word.
  assign w_unused   = &{1'b0, bus.address_to_mem[1:0]};

  assign w_in_ram   = (bus.address_to_mem[31:AW+2] == '0);
  assign w_in_mmio  = (bus.address_to_mem[31:4] == MMIO_BASE[31:4]);
  assign w_off      = bus.address_to_mem[3:2];
  assign w_word     = bus.address_to_mem[AW+1:2];
  assign w_mmio_we  = bus.write_enable && !w_in_ram && w_in_mmio;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = !w_empty && bus.tx_ready;
  assign w_push_req = w_mmio_we && (w_off == 2'd0);
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_push_rej = w_push_req && !w_push_ok;
  assign w_ovf_clr  = w_mmio_we && (w_off == 2'd1) && bus.data_to_mem[2];
  assign w_cyc_we   = w_mmio_we && (w_off == 2'd2);

  assign w_status   = {23'd0, 5'(r_count), 1'b0, r_overflow, w_full, w_empty};

  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 32'd0 : r_fifo[r_rd_ptr];

  always_comb begin
    w_rdata = 32'd0;
    if (w_in_ram) begin
      w_rdata = r_ram[w_word];
    end else if (w_in_mmio) begin
      case (w_off)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = r_cycles;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_from_mem = w_rdata;

  // RAM and FIFO storage carry no reset; FIFO validity lives in the pointers/count.
  always_ff @(posedge clk) begin
    if (bus.write_enable && w_in_ram) begin
      r_ram[w_word] <= bus.data_to_mem;
    end
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus.data_to_mem;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycles   <= 32'd0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A rejected push in the same cycle as a clear leaves overflow set.
      if (w_push_rej) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      r_cycles <= w_cyc_we ? bus.data_to_mem : r_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset sequence, then
// randomized traffic against a queue-based reference model.
module tb_data_mem_responder;

  localparam int          DEPTH      = 256;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [31:0] A_TX       = BASE + 32'h0;
  localparam logic [31:0] A_ST       = BASE + 32'h4;
  localparam logic [31:0] A_CYC      = BASE + 32'h8;
  localparam logic [31:0] A_C        = BASE + 32'hC;

  logic clk;
  logic reset;
  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_BASE(BASE)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_q [$];
  logic        m_ovf;
  logic [31:0] m_cyc;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_txd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] data,
                              input logic rdy, input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_valid, input logic [31:0] exp_txd);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_txd = exp_txd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: returns 0 when the RAM word was never written (unknown).
  function automatic logic model_read(input logic [31:0] a, output logic [31:0] v);
    int n;
    v = 32'd0;
    if (a < DEPTH * 4) begin
      if (m_ram.exists(a >> 2)) begin
        v = m_ram[a >> 2];
        return 1'b1;
      end
      return 1'b0;
    end
    if ((a & 32'hFFFF_FFF0) == BASE) begin
      n = m_q.size();
      case ((a - BASE) >> 2)
        1: v = (n << 4) | (m_ovf ? 4 : 0) | ((n == FIFO_DEPTH) ? 2 : 0) | ((n == 0) ? 1 : 0);
        2: v = m_cyc;
        default: v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy, input bit use_model,
                      output logic [31:0] rd, output logic vld, output logic [31:0] txd);
    logic [31:0] exp_rd;
    logic        known;
    bit          is_mmio;
    bit          pop;
    bit          push_req;
    bit          clr;
    bit          rej;
    logic [31:0] off;
    @(negedge clk);
    reset              = rst;
    bus.write_enable   = we;
    bus.address_to_mem = addr;
    bus.data_to_mem    = data;
    bus.tx_ready       = rdy;
    if (!rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
    end
    #1;
    rd  = bus.data_from_mem;
    vld = bus.tx_valid;
    txd = bus.tx_data;
    if (use_model) begin
      known = model_read(addr, exp_rd);
      if (known) chk("model_rdata", rd, exp_rd);
      chk("model_tx_valid", {31'd0, vld}, {31'd0, m_q.size() != 0});
      chk("model_tx_data", txd, (m_q.size() != 0) ? m_q[0] : 32'd0);
    end
    @(posedge clk);
    if (we && addr < DEPTH * 4) m_ram[addr >> 2] = data;
    if (rst) begin
      is_mmio  = (addr >= DEPTH * 4) && ((addr & 32'hFFFF_FFF0) == BASE);
      off      = (addr - BASE) >> 2;
      pop      = (m_q.size() != 0) && rdy;
      push_req = we && is_mmio && off == 0;
      clr      = we && is_mmio && off == 1 && data[2];
      rej      = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push_req) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(data);
        else rej = 1'b1;
      end
      if (rej) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_cyc = (we && is_mmio && off == 2) ? data : m_cyc + 32'd1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        vld;
    logic [31:0] txd;
    logic [31:0] a;
    logic [31:0] d;

    reset = 1'b0;
    bus.write_enable = 1'b0; bus.address_to_mem = 32'd0;
    bus.data_to_mem = 32'd0; bus.tx_ready = 1'b0;
    m_ovf = 1'b0; m_cyc = 32'd0;

    step(1'b0, 1'b0, A_ST, 32'd0, 1'b0, 1'b1, rd, vld, txd);
    chk("reset_status", rd, 32'h1);
    step(1'b0, 1'b0, A_CYC, 32'd0, 1'b0, 1'b1, rd, vld, txd);
    chk("reset_cycles", rd, 32'h0);

    // we, addr, data, rdy, chk_rd, exp_rd, exp_valid, exp_txd
    tbl.push_back(mk(1, 32'h10,     32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 32'h10,     32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(0, 32'h13,     32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(0, 32'h400,    32'h0,         0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(1, A_TX,       32'd1,         0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(1, A_TX,       32'd2,         0, 1, 32'h0,         1, 1));
    tbl.push_back(mk(1, A_TX,       32'd3,         0, 1, 32'h0,         1, 1));
    tbl.push_back(mk(1, A_TX,       32'd4,         0, 1, 32'h0,         1, 1));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h42,        1, 1));
    tbl.push_back(mk(1, A_TX,       32'd5,         0, 1, 32'h0,         1, 1));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h46,        1, 1));
    tbl.push_back(mk(1, A_ST,       32'h4,         0, 1, 32'h46,        1, 1));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h42,        1, 1));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h42,        1, 1));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h30,        1, 2));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h20,        1, 3));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h10,        1, 4));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h01,        0, 0));
    tbl.push_back(mk(1, A_TX,       32'd5,         0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(1, A_TX,       32'd6,         0, 1, 32'h0,         1, 5));
    tbl.push_back(mk(1, A_TX,       32'd7,         0, 1, 32'h0,         1, 5));
    tbl.push_back(mk(1, A_TX,       32'd8,         0, 1, 32'h0,         1, 5));
    tbl.push_back(mk(1, A_TX,       32'd9,         1, 1, 32'h0,         1, 5));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h42,        1, 6));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h42,        1, 6));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h30,        1, 7));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h20,        1, 8));
    tbl.push_back(mk(0, A_ST,       32'h0,         1, 1, 32'h10,        1, 9));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h01,        0, 0));
    tbl.push_back(mk(1, A_CYC,      32'hFFFF_FFFE, 0, 0, 32'h0,         0, 0));
    tbl.push_back(mk(0, A_CYC,      32'h0,         0, 1, 32'hFFFF_FFFE, 0, 0));
    tbl.push_back(mk(0, A_CYC,      32'h0,         0, 1, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(mk(0, A_CYC,      32'h0,         0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(1, A_C,        32'h1234,      0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(1, BASE + 32'h10, 32'h5555,   0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(0, A_C,        32'h0,         0, 1, 32'h0,         0, 0));
    tbl.push_back(mk(0, A_ST,       32'h0,         0, 1, 32'h01,        0, 0));
    tbl.push_back(mk(0, 32'h10,     32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].rdy, 1'b0, rd, vld, txd);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_tx_valid", i), {31'd0, vld}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_tx_data", i), txd, tbl[i].exp_txd);
    end

    // Reset mid-operation with two words queued.
    step(1'b1, 1'b1, A_TX, 32'hA, 1'b0, 1'b0, rd, vld, txd);
    step(1'b1, 1'b1, A_TX, 32'hB, 1'b0, 1'b0, rd, vld, txd);
    step(1'b1, 1'b0, A_ST, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("queued_status", rd, 32'h20);
    step(1'b0, 1'b0, A_ST, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("rst_mid_status", rd, 32'h1);
    chk("rst_mid_tx_valid", {31'd0, vld}, 32'd0);
    chk("rst_mid_tx_data", txd, 32'd0);
    step(1'b0, 1'b0, A_CYC, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("rst_mid_cycles", rd, 32'h0);
    step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("rst_mid_ram", rd, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, A_CYC, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("rst_release_cycles", rd, 32'h0);
    step(1'b1, 1'b0, A_CYC, 32'h0, 1'b0, 1'b0, rd, vld, txd);
    chk("rst_first_edge_cycles", rd, 32'h1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        2:       a = 32'h400 + $urandom_range(0, 4095);
        3, 4:    a = BASE + ($urandom_range(0, 1) == 0 ? 32'd0 : $urandom_range(0, 15));
        default: a = $urandom;
      endcase
      d = $urandom;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), a, d,
           ($urandom_range(0, 2) == 0), 1'b1, rd, vld, txd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
